// File: rtl/alu_pkg.sv
// Shared ALU definitions for the add/subtract datapath.
// Contents:
//   op_t     - operation code: ADD, ADC, SUB, SBB
//   flags_t  - packed {n, z, c, v} condition flags
//   FLAG_*   - bit positions of each flag inside a packed flags vector
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    ADC = 2'b01,
    SUB = 2'b10,
    SBB = 2'b11
  } op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result channel of the pipelined adder/subtractor.
// Signals:
//   in_valid, in_ready  - operand beat handshake
//   a, b, cin, op       - operands, carry-in and operation code
//   out_valid, out_ready - result handshake
//   sum, flags          - result and {n, z, c, v}
// Modports:
//   master - operand source / result consumer (drives operands, out_ready)
//   slave  - the adder/subtractor itself
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  flags_t           flags;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, flags
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, flags
  );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder segment.
// Ports:
//   x, y      in  CHUNK  addends
//   ci        in  1      carry into bit 0
//   s         out CHUNK  sum
//   co        out 1      carry out of the top bit
//   c_msb_in  out 1      carry into the top bit (overflow detection)
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
  end

  assign co       = carry[CHUNK];
  assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with NZCV flags.
// The WIDTH-bit carry chain is cut into CHUNK-bit ripple segments with one
// register stage per segment, so results appear STAGES = WIDTH/CHUNK cycles
// after the operand beat is accepted. WIDTH must be a multiple of CHUNK.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset; clears all in-flight beats
//   bus    slave modport of pipelined_addsub_if (operands, handshakes,
//          sum and flags)
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_addsub_if.slave  bus
);
  import alu_pkg::*;

  localparam int STAGES = WIDTH / CHUNK;

  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;
  logic             stall;

  // Stage inputs: for stage 0 these are the live operands, for stage k the
  // registers of stage k-1.
  logic [STAGES-1:0][WIDTH-1:0] x_in, y_in, s_in;
  logic [STAGES-1:0]            c_in, z_in, vld_in;

  logic [STAGES-1:0][CHUNK-1:0] chunk_s;
  logic [STAGES-1:0]            chunk_co, chunk_cm;
  logic [STAGES-1:0][WIDTH-1:0] s_nxt;
  logic [STAGES-1:0]            z_nxt;

  // Stage registers. x_q/y_q carry the operand chunks that are still to be
  // added; s_q holds the chunks already summed; z_q is the running
  // "all finished chunks are zero" bit.
  logic [STAGES-1:0][WIDTH-1:0] x_q, y_q, s_q;
  logic [STAGES-1:0]            c_q, z_q, vld_q;
  logic                         m_q;

  logic [3:0] flag_vec;

  // Subtraction is A + ~B + carry; carry-in is 1 for SUB, cin for ADC/SBB.
  always_comb begin
    y_eff   = bus.b;
    cin_eff = 1'b0;
    case (bus.op)
      ADD: begin
        y_eff   = bus.b;
        cin_eff = 1'b0;
      end
      ADC: begin
        y_eff   = bus.b;
        cin_eff = bus.cin;
      end
      SUB: begin
        y_eff   = ~bus.b;
        cin_eff = 1'b1;
      end
      SBB: begin
        y_eff   = ~bus.b;
        cin_eff = bus.cin;
      end
      default: begin
        y_eff   = bus.b;
        cin_eff = 1'b0;
      end
    endcase
  end

  // The whole pipe freezes only when a finished result is not taken.
  assign stall        = vld_q[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign x_in[k]   = bus.a;
      assign y_in[k]   = y_eff;
      assign c_in[k]   = cin_eff;
      assign s_in[k]   = '0;
      assign z_in[k]   = 1'b1;
      assign vld_in[k] = bus.in_valid;
    end else begin : g_next
      assign x_in[k]   = x_q[k-1];
      assign y_in[k]   = y_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign s_in[k]   = s_q[k-1];
      assign z_in[k]   = z_q[k-1];
      assign vld_in[k] = vld_q[k-1];
    end

    addsub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .x       (x_in[k][k*CHUNK +: CHUNK]),
      .y       (y_in[k][k*CHUNK +: CHUNK]),
      .ci      (c_in[k]),
      .s       (chunk_s[k]),
      .co      (chunk_co[k]),
      .c_msb_in(chunk_cm[k])
    );
  end

  // Insert each stage's fresh chunk into the partially built sum and fold
  // its zero test into the running zero bit.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k]                   = s_in[k];
      s_nxt[k][k*CHUNK +: CHUNK] = chunk_s[k];
      z_nxt[k]                   = z_in[k] & ~|chunk_s[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      z_q   <= '0;
      m_q   <= 1'b0;
    end else if (!stall) begin
      vld_q <= vld_in;
      x_q   <= x_in;
      y_q   <= y_in;
      s_q   <= s_nxt;
      c_q   <= chunk_co;
      z_q   <= z_nxt;
      m_q   <= chunk_cm[STAGES-1];
    end
  end

  // Overflow is carry into the MSB differing from carry out of it; every
  // flag comes from last-stage registers so it is held during a stall.
  always_comb begin
    flag_vec         = '0;
    flag_vec[FLAG_N] = s_q[STAGES-1][WIDTH-1];
    flag_vec[FLAG_Z] = z_q[STAGES-1];
    flag_vec[FLAG_C] = c_q[STAGES-1];
    flag_vec[FLAG_V] = c_q[STAGES-1] ^ m_q;
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.flags     = flags_t'(flag_vec);

  // Operand bits already consumed by earlier stages are never read again.
  logic unused_bits;
  assign unused_bits = ^{chunk_cm, x_q, y_q};

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor. Generalises the 4-bit ripple-carry adder to WIDTH bits by splitting the carry chain into CHUNK-bit ripple segments, with one register stage per segment. Adds add-with-carry, subtract and subtract-with-borrow modes, NZCV flags, and a valid/ready handshake on both sides. Sits between the operand register file and the ALU result mux; accepts one operation per cycle when not stalled.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits per carry segment; one pipeline stage per segment.
- STAGES, WIDTH/CHUNK (derived localparam, not overridable), pipeline depth.

- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, used only by ADC and SBB.
- op  in  2  operation code, one of ADD, ADC, SUB, SBB.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- flags  out  4  {n, z, c, v}.

## Operation
- The block accepts a beat when in_valid && in_ready.
- Effective operands per op:
  - ADD: A + B + 0.
  - ADC: A + B + cin.
  - SUB: A + ~B + 1.
  - SBB: A + ~B + cin (carry = NOT borrow).
- Stage k (0..STAGES-1) adds chunk k of the effective operands plus the registered carry from stage k-1.
  - Stage 0 uses the effective carry-in.
  - Higher chunks travel through skew registers.
  - Completed lower chunks are carried forward, so all chunks align at the output.
- Flags are taken at the final stage:
  - c = carry out of bit WIDTH-1.
  - v = carry into MSB XOR carry out of MSB.
  - n = sum[WIDTH-1].
  - z = sum == 0. A per-chunk zero bit accumulates through the stages with an AND.
- For SUB, c=1 means no borrow.
- Arithmetic is modulo 2^WIDTH. No saturation.
- op values outside the encoding cannot occur (2-bit field, 4 codes).

## Timing
- Latency is STAGES cycles from accept to out_valid; the default is 4.
- Throughput is one beat per cycle when out_ready=1.
- Stall is global: stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_ready.
  - While stalled, every stage register, including its valid bit, holds.
- Bubbles advance normally, with no compaction. A stage valid bit is 0 for a bubble, and its data is don't-care.
- sum and flags are stable while out_valid && !out_ready. A new result replaces them only after a handshake or a bubble.
- Asynchronous reset while rst_n=0:
  - All stage valid bits clear, so out_valid=0, sum=0 and flags=0.
  - in_ready=1 once in reset, since out_valid=0.
  - In-flight beats are discarded. Nothing is replayed after reset releases.
- An input beat and an output handshake in the same cycle are both honoured, and the pipe shifts by one.
- in_valid with in_ready=0: the beat is not taken, and the source must hold it.

## Structure
- Shared package alu_pkg:
  - op enum: ADD=2'b00, ADC=2'b01, SUB=2'b10, SBB=2'b11.
  - flags struct {n, z, c, v}.
  - Flag bit-index constants.
- Sub-module addsub_chunk:
  - Combinational CHUNK-bit ripple adder with inputs x, y, ci.
  - Outputs s, co, and c_msb_in (carry into the top bit, used for v in the last chunk).
  - Instantiated STAGES times in a generate loop.
- Top level holds the effective-operand logic, skew/deskew registers, valid chain, stall logic and flag generation.

## Test plan
- ADD 0xFFFF + 0x0001 (WIDTH=16, CHUNK=4) -> after 4 cycles sum=0x0000, flags n=0 z=1 c=1 v=0.
- ADD 0x7FFF + 0x0001 -> sum=0x8000, n=1 z=0 c=0 v=1. SUB 0x0003 - 0x0005 -> sum=0xFFFE, n=1 c=0 v=0.
- ADC 0x00FF + 0x0000 with cin=1 -> 0x0100, c=0. SBB 0x0010 - 0x0001 with cin=0 -> 0x000E, c=1.
- Back-to-back: 8 random beats on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles from cycle 4, in order, matching the reference model.
- Backpressure: hold out_ready=0 for 6 cycles with pipe full -> in_ready=0, sum/flags stable. Release -> no beat lost or duplicated.
- Reset: assert rst_n=0 with 3 beats in flight -> out_valid drops immediately. After release, no stale results appear, and the first new beat emerges after 4 cycles.
